// File: rtl/axi_wr_arbiter_2to1.sv
// Two-into-one AXI4 write-channel arbiter: round-robin whole-burst grants held
// from AW through B, with WLAST regenerated from a beat counter.
module axi_wr_arbiter_2to1 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   S0_AXI_AWADDR,
  input  logic [7:0]          S0_AXI_AWLEN,
  input  logic                S0_AXI_AWVALID,
  output logic                S0_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S0_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S0_AXI_WSTRB,
  input  logic                S0_AXI_WLAST,
  input  logic                S0_AXI_WVALID,
  output logic                S0_AXI_WREADY,
  output logic [1:0]          S0_AXI_BRESP,
  output logic                S0_AXI_BVALID,
  input  logic                S0_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S1_AXI_AWADDR,
  input  logic [7:0]          S1_AXI_AWLEN,
  input  logic                S1_AXI_AWVALID,
  output logic                S1_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S1_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S1_AXI_WSTRB,
  input  logic                S1_AXI_WLAST,
  input  logic                S1_AXI_WVALID,
  output logic                S1_AXI_WREADY,
  output logic [1:0]          S1_AXI_BRESP,
  output logic                S1_AXI_BVALID,
  input  logic                S1_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [7:0]          M_AXI_AWLEN,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic                GRANT,
  output logic                PROTO_ERR
);

  localparam int unsigned LEN_W = 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e           state_q, state_d;
  logic             g_q, g_d;
  logic             p_q, p_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             proto_err_q, proto_err_d;

  logic             sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
  logic [LEN_W-1:0] sel_awlen;
  logic             aw_ready_c, w_ready_c, b_valid_c, last_beat_c;

  // Payloads always follow the granted requester; only handshakes are gated by state.
  assign M_AXI_AWADDR = g_q ? S1_AXI_AWADDR : S0_AXI_AWADDR;
  assign sel_awlen    = g_q ? S1_AXI_AWLEN  : S0_AXI_AWLEN;
  assign M_AXI_AWLEN  = sel_awlen;
  assign M_AXI_WDATA  = g_q ? S1_AXI_WDATA  : S0_AXI_WDATA;
  assign M_AXI_WSTRB  = g_q ? S1_AXI_WSTRB  : S0_AXI_WSTRB;
  assign sel_awvalid  = g_q ? S1_AXI_AWVALID : S0_AXI_AWVALID;
  assign sel_wvalid   = g_q ? S1_AXI_WVALID  : S0_AXI_WVALID;
  assign sel_wlast    = g_q ? S1_AXI_WLAST   : S0_AXI_WLAST;
  assign sel_bready   = g_q ? S1_AXI_BREADY  : S0_AXI_BREADY;
  assign last_beat_c  = (cnt_q == len_q);

  assign S0_AXI_AWREADY = aw_ready_c & ~g_q;
  assign S1_AXI_AWREADY = aw_ready_c &  g_q;
  assign S0_AXI_WREADY  = w_ready_c  & ~g_q;
  assign S1_AXI_WREADY  = w_ready_c  &  g_q;
  assign S0_AXI_BVALID  = b_valid_c  & ~g_q;
  assign S1_AXI_BVALID  = b_valid_c  &  g_q;
  assign S0_AXI_BRESP   = M_AXI_BRESP;
  assign S1_AXI_BRESP   = M_AXI_BRESP;

  assign GRANT     = g_q;
  assign PROTO_ERR = proto_err_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= IDLE;
      g_q         <= 1'b0;
      p_q         <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    p_d           = p_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    proto_err_d   = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    aw_ready_c    = 1'b0;
    w_ready_c     = 1'b0;
    b_valid_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (S0_AXI_AWVALID && S1_AXI_AWVALID) begin
          g_d     = p_q;
          state_d = ADDR;
        end else if (S0_AXI_AWVALID) begin
          g_d     = 1'b0;
          state_d = ADDR;
        end else if (S1_AXI_AWVALID) begin
          g_d     = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        M_AXI_AWVALID = sel_awvalid;
        aw_ready_c    = M_AXI_AWREADY;
        if (sel_awvalid && M_AXI_AWREADY) begin
          len_d   = sel_awlen;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        M_AXI_WVALID = sel_wvalid;
        M_AXI_WLAST  = last_beat_c;
        w_ready_c    = M_AXI_WREADY;
        if (sel_wvalid && M_AXI_WREADY) begin
          // Requester WLAST is only checked; burst length comes from len_q.
          proto_err_d = (sel_wlast != last_beat_c);
          if (last_beat_c) begin
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      RESP: begin
        b_valid_c    = M_AXI_BVALID;
        M_AXI_BREADY = sel_bready;
        if (M_AXI_BVALID && sel_bready) begin
          p_d     = ~g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_wr_arbiter_2to1.sv
// Scoreboard bench for axi_wr_arbiter_2to1: directed bursts push expected
// AW/W/B traffic; a negedge monitor pops and compares on every handshake.
module tb_axi_wr_arbiter_2to1;
  localparam int TMO = 2000;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  logic [31:0] s_awaddr [2];
  logic [7:0]  s_awlen  [2];
  logic        s_awvalid[2];
  logic        s_awready[2];
  logic [31:0] s_wdata  [2];
  logic [3:0]  s_wstrb  [2];
  logic        s_wlast  [2];
  logic        s_wvalid [2];
  logic        s_wready [2];
  logic [1:0]  s_bresp  [2];
  logic        s_bvalid [2];
  logic        s_bready [2];

  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic        grant, proto_err;

  axi_wr_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S0_AXI_AWADDR(s_awaddr[0]), .S0_AXI_AWLEN(s_awlen[0]), .S0_AXI_AWVALID(s_awvalid[0]),
    .S0_AXI_AWREADY(s_awready[0]), .S0_AXI_WDATA(s_wdata[0]), .S0_AXI_WSTRB(s_wstrb[0]),
    .S0_AXI_WLAST(s_wlast[0]), .S0_AXI_WVALID(s_wvalid[0]), .S0_AXI_WREADY(s_wready[0]),
    .S0_AXI_BRESP(s_bresp[0]), .S0_AXI_BVALID(s_bvalid[0]), .S0_AXI_BREADY(s_bready[0]),
    .S1_AXI_AWADDR(s_awaddr[1]), .S1_AXI_AWLEN(s_awlen[1]), .S1_AXI_AWVALID(s_awvalid[1]),
    .S1_AXI_AWREADY(s_awready[1]), .S1_AXI_WDATA(s_wdata[1]), .S1_AXI_WSTRB(s_wstrb[1]),
    .S1_AXI_WLAST(s_wlast[1]), .S1_AXI_WVALID(s_wvalid[1]), .S1_AXI_WREADY(s_wready[1]),
    .S1_AXI_BRESP(s_bresp[1]), .S1_AXI_BVALID(s_bvalid[1]), .S1_AXI_BREADY(s_bready[1]),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWLEN(m_awlen), .M_AXI_AWVALID(m_awvalid),
    .M_AXI_AWREADY(m_awready), .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb),
    .M_AXI_WLAST(m_wlast), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
    .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
    .GRANT(grant), .PROTO_ERR(proto_err)
  );

  int checks = 0;
  int failures = 0;
  int proto_cnt = 0;
  logic wready_toggle = 1'b0;

  logic [40:0] aw_exp[$];
  logic [36:0] w_exp[$];
  logic [2:0]  b_exp[$];
  logic [40:0] aw_e;
  logic [36:0] w_e;
  logic [2:0]  b_e;
  logic        nb, nw;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tmo_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  function automatic void push_burst(input int s, input logic [31:0] addr,
                                     input logic [7:0] len, input logic [1:0] resp);
    aw_exp.push_back({1'(s), addr, len});
    for (int b = 0; b <= int'(len); b++)
      w_exp.push_back({32'(addr + 32'(b)), 4'(b + 1), (b == int'(len))});
    b_exp.push_back({1'(s), resp});
  endfunction

  // Requester driver; call at posedge+1, returns at posedge+1 after the B handshake.
  task automatic drive_burst(input int s, input logic [31:0] addr, input logic [7:0] len,
                             input int bad_beat, input int bdelay);
    int n;
    s_awaddr[s] = addr; s_awlen[s] = len; s_awvalid[s] = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!s_awready[s] && n < TMO) begin @(negedge ACLK); n++; end
    if (n >= TMO) begin tmo_fail("aw_wait"); return; end
    @(posedge ACLK); #1;
    s_awvalid[s] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_wdata[s]  = 32'(addr + 32'(b));
      s_wstrb[s]  = 4'(b + 1);
      s_wlast[s]  = (b == int'(len)) || (b == bad_beat);
      s_wvalid[s] = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!s_wready[s] && n < TMO) begin @(negedge ACLK); n++; end
      if (n >= TMO) begin tmo_fail("w_wait"); return; end
      @(posedge ACLK); #1;
    end
    s_wvalid[s] = 1'b0; s_wlast[s] = 1'b0;
    for (int i = 0; i < bdelay; i++) begin @(posedge ACLK); #1; end
    s_bready[s] = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!s_bvalid[s] && n < TMO) begin @(negedge ACLK); n++; end
    if (n >= TMO) begin tmo_fail("b_wait"); return; end
    @(posedge ACLK); #1;
    s_bready[s] = 1'b0;
  endtask

  // Downstream slave: decide at negedge, apply just after posedge.
  always begin
    @(negedge ACLK);
    nb = m_bvalid;
    if (ARESET) nb = 1'b0;
    else begin
      if (m_bvalid && m_bready) nb = 1'b0;
      if (m_wvalid && m_wready && m_wlast) nb = 1'b1;
    end
    nw = wready_toggle ? ~m_wready : 1'b1;
    @(posedge ACLK); #1;
    m_bvalid = nb;
    m_wready = nw;
  end

  // Monitor: compare every handshake against the scoreboard queues.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (m_awvalid && m_awready) begin
        if (aw_exp.size() == 0) tmo_fail("aw_unexpected");
        else begin aw_e = aw_exp.pop_front(); chk("aw_grant_addr_len", {grant, m_awaddr, m_awlen}, aw_e); end
      end
      if (m_wvalid && m_wready) begin
        if (w_exp.size() == 0) tmo_fail("w_unexpected");
        else begin w_e = w_exp.pop_front(); chk("w_data_strb_last", {m_wdata, m_wstrb, m_wlast}, w_e); end
      end
      for (int s = 0; s < 2; s++) begin
        if (s_bvalid[s] && s_bready[s]) begin
          if (b_exp.size() == 0) tmo_fail("b_unexpected");
          else begin b_e = b_exp.pop_front(); chk("b_port_resp", {1'(s), s_bresp[s]}, b_e); end
        end
      end
      if (proto_err) proto_cnt++;
    end
  end

  initial begin
    int p0;
    logic acc;
    bit done;
    for (int s = 0; s < 2; s++) begin
      s_awaddr[s] = '0; s_awlen[s] = '0; s_awvalid[s] = 1'b0; s_wdata[s] = '0;
      s_wstrb[s] = '0; s_wlast[s] = 1'b0; s_wvalid[s] = 1'b0; s_bready[s] = 1'b0;
    end
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
    ARESET = 1'b0;
    #2 ARESET = 1'b1;
    s_awvalid[0] = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("rst_outputs", {m_awvalid, m_wvalid, m_wlast, m_bready, proto_err,
                        s_awready[0], s_wready[0], s_bvalid[0], s_awready[1], s_wready[1], s_bvalid[1]}, 0);
    chk("rst_grant", grant, 0);
    s_awvalid[0] = 1'b0;
    @(negedge ACLK); ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Contention, AWLEN=0: strict alternation S0,S1,...
    p0 = proto_cnt;
    for (int k = 0; k < 4; k++) begin
      push_burst(0, 32'h1000_0000 + 32'(k * 16), 8'd0, 2'b00);
      push_burst(1, 32'h2000_0000 + 32'(k * 16), 8'd0, 2'b00);
    end
    fork
      for (int k = 0; k < 4; k++) drive_burst(0, 32'h1000_0000 + 32'(k * 16), 8'd0, -1, 0);
      for (int k = 0; k < 4; k++) drive_burst(1, 32'h2000_0000 + 32'(k * 16), 8'd0, -1, 0);
    join
    chk("contend_proto", proto_cnt - p0, 0);
    chk("contend_aw_drained", aw_exp.size(), 0);

    // Single S0 burst AWLEN=3, arbitration latency and S1 isolation.
    push_burst(0, 32'h4000_0000, 8'd3, 2'b00);
    done = 1'b0;
    acc = 1'b0;
    fork
      begin drive_burst(0, 32'h4000_0000, 8'd3, -1, 0); done = 1'b1; end
      begin
        int n = 0;
        @(negedge ACLK);
        while (!s_awvalid[0] && n < TMO) begin @(negedge ACLK); n++; end
        chk("aw_latency_n", m_awvalid, 0);
        @(negedge ACLK);
        chk("aw_latency_n1", m_awvalid, 1);
      end
      begin
        int n = 0;
        while (!done && n < TMO) begin
          @(negedge ACLK);
          acc = acc | s_awready[1] | s_wready[1] | s_bvalid[1];
          n++;
        end
        chk("s1_isolated", acc, 0);
      end
    join

    // S1 AWLEN=15 with WREADY toggling.
    wready_toggle = 1'b1;
    m_bresp = 2'b10;
    push_burst(1, 32'h5000_0100, 8'd15, 2'b10);
    drive_burst(1, 32'h5000_0100, 8'd15, -1, 0);
    wready_toggle = 1'b0;
    repeat (2) begin @(posedge ACLK); #1; end

    // S0 early WLAST on beat 2 of AWLEN=3.
    m_bresp = 2'b00;
    p0 = proto_cnt;
    push_burst(0, 32'h6000_0000, 8'd3, 2'b00);
    drive_burst(0, 32'h6000_0000, 8'd3, 1, 0);
    chk("proto_err_pulses", proto_cnt - p0, 1);

    // B held with S0_BREADY low; S1 must wait.
    m_bresp = 2'b11;
    push_burst(0, 32'h7000_0000, 8'd1, 2'b11);
    push_burst(1, 32'h7100_0000, 8'd0, 2'b11);
    fork
      drive_burst(0, 32'h7000_0000, 8'd1, -1, 10);
      begin repeat (3) begin @(posedge ACLK); #1; end drive_burst(1, 32'h7100_0000, 8'd0, -1, 0); end
      begin
        int n = 0;
        @(negedge ACLK);
        while (!s_bvalid[0] && n < TMO) begin @(negedge ACLK); n++; end
        for (int i = 0; i < 9; i++) begin
          chk("b_hold", {m_bready, s_awready[1], s_bvalid[0]}, 3'b001);
          @(negedge ACLK);
        end
      end
    join

    // AWLEN=255: 256 beats, WLAST only on the last.
    m_bresp = 2'b01;
    p0 = proto_cnt;
    push_burst(0, 32'h8000_0000, 8'd255, 2'b01);
    drive_burst(0, 32'h8000_0000, 8'd255, -1, 0);
    chk("len255_proto", proto_cnt - p0, 0);

    // Reset mid-DATA at beat 5 of 8, then a fresh S1 burst.
    m_bresp = 2'b00;
    aw_exp.push_back({1'b0, 32'h9000_0000, 8'd7});
    for (int b = 0; b < 4; b++) w_exp.push_back({32'h9000_0000 + 32'(b), 4'(b + 1), 1'b0});
    s_awaddr[0] = 32'h9000_0000; s_awlen[0] = 8'd7; s_awvalid[0] = 1'b1;
    begin
      int n = 0;
      @(negedge ACLK);
      while (!s_awready[0] && n < TMO) begin @(negedge ACLK); n++; end
      if (n >= TMO) tmo_fail("rst_aw_wait");
    end
    @(posedge ACLK); #1;
    s_awvalid[0] = 1'b0;
    for (int b = 0; b < 5; b++) begin
      s_wdata[0] = 32'h9000_0000 + 32'(b); s_wstrb[0] = 4'(b + 1);
      s_wlast[0] = 1'b0; s_wvalid[0] = 1'b1;
      if (b < 4) begin @(posedge ACLK); #1; end
    end
    #2;
    chk("pre_rst_wvalid", m_wvalid, 1);
    ARESET = 1'b1;
    #1;
    chk("rst_async_outputs", {m_awvalid, m_wvalid, m_wlast, m_bready, proto_err,
                              s_awready[0], s_wready[0], s_bvalid[0]}, 0);
    chk("rst_async_grant", grant, 0);
    chk("rst_w_drained", w_exp.size(), 0);
    s_wvalid[0] = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    push_burst(1, 32'hA000_0000, 8'd2, 2'b00);
    drive_burst(1, 32'hA000_0000, 8'd2, -1, 0);

    repeat (3) @(negedge ACLK);
    chk("final_aw_empty", aw_exp.size(), 0);
    chk("final_w_empty", w_exp.size(), 0);
    chk("final_b_empty", b_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
